// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order imem requests and buffers responses for decode.
// Define FETCH_MISALIGN_CHK_EN to add misalign_err for redirects to non-word-aligned targets.
module fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
`ifdef FETCH_MISALIGN_CHK_EN
    output logic [XLEN-1:0] id_pc,
    output logic            misalign_err
`else
    output logic [XLEN-1:0] id_pc
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   inflight_q, drop_q, cnt_q, drop_d;
    logic [AW-1:0]   wr_q, rd_q, tw_q, tr_q;
    logic [XLEN-1:0] tag_q [FIFO_DEPTH];
    logic [XLEN-1:0] pcs_q [FIFO_DEPTH];
    logic [31:0]     ins_q [FIFO_DEPTH];
    logic            acc, push, pop;

    assign imem_req_valid = state_q == RUN && !redirect_valid && (inflight_q + cnt_q) < CW'(FIFO_DEPTH);
    assign imem_req_addr  = pc_q;
    assign acc            = imem_req_valid && imem_req_ready;
    assign push           = imem_resp_valid && state_q == RUN && !redirect_valid;
    assign id_valid       = cnt_q != '0 && !redirect_valid;
    assign pop            = id_valid && id_ready;
    assign id_instr       = ins_q[rd_q];
    assign id_pc          = pcs_q[rd_q];
    // Responses still owed after a redirect; one landing this cycle is discarded and already settled.
    assign drop_d         = inflight_q + CW'(acc) - CW'(imem_resp_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            {wr_q, rd_q, tw_q, tr_q} <= '0;
            tag_q      <= '{default: '0};
            pcs_q      <= '{default: '0};
            ins_q      <= '{default: '0};
        end else if (state_q == BOOT) begin
            state_q <= RUN;
        end else if (redirect_valid) begin
            pc_q       <= {redirect_pc[XLEN-1:2], 2'b00};
            {wr_q, rd_q, tw_q, tr_q} <= '0;
            cnt_q      <= '0;
            drop_q     <= drop_d;
            inflight_q <= drop_d;
            if (state_q == RUN)
                state_q <= (inflight_q + CW'(acc)) != '0 ? DRAIN : RUN;
        end else if (state_q == DRAIN) begin
            if (imem_resp_valid)
                {drop_q, inflight_q} <= {drop_q - CW'(1), inflight_q - CW'(1)};
            else if (drop_q == '0)
                state_q <= RUN;
        end else begin
            if (acc) begin
                pc_q        <= pc_q + XLEN'(4);
                tag_q[tw_q] <= pc_q;
                tw_q        <= tw_q + AW'(1);
            end
            if (push) begin
                ins_q[wr_q] <= imem_resp_data;
                pcs_q[wr_q] <= tag_q[tr_q];
                wr_q        <= wr_q + AW'(1);
                tr_q        <= tr_q + AW'(1);
            end
            if (pop)
                rd_q <= rd_q + AW'(1);
            inflight_q <= inflight_q + CW'(acc) - CW'(push);
            cnt_q      <= cnt_q + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    logic mis_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mis_q <= 1'b0;
        else
            mis_q <= redirect_valid && redirect_pc[1:0] != 2'b00;
    end
    assign misalign_err = mis_q;
`else
    logic unused_lo;
    assign unused_lo = ^redirect_pc[1:0];
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios against a variable-latency memory model and an id scoreboard.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam int FIFO_DEPTH = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic imem_req_valid, id_valid;
    logic imem_req_ready = 1'b1;
    logic imem_resp_valid = 1'b0;
    logic redirect_valid = 1'b0;
    logic id_ready = 1'b1;
    logic [31:0] imem_req_addr, id_instr, id_pc;
    logic [31:0] imem_resp_data = 32'h0;
    logic [31:0] redirect_pc = 32'h0;
`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_err;
`endif
    typedef struct {logic [31:0] a; int due;} mreq_t;
    mreq_t mq[$];
    logic [63:0] sb[$];
    logic [31:0] exp_pc = RST_PC;
    int cyc = 0, lat = 1, n_chk = 0, n_fail = 0, n_id = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
`ifdef FETCH_MISALIGN_CHK_EN
        .id_pc(id_pc), .misalign_err(misalign_err)
`else
        .id_pc(id_pc)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [31:0] pc);
        redirect_pc = pc;
        redirect_valid = 1'b1;
        @(posedge clk); #1;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_acc(input string tag, input logic [31:0] exp);
        int k = 0;
        do begin @(negedge clk); #1; k++; end while (!(imem_req_valid && imem_req_ready) && k < 60);
        chk(tag, 64'({imem_req_valid, imem_req_ready, imem_req_addr}), 64'({2'b11, exp}));
    endtask

    task automatic wait_id(input string tag, input logic [31:0] exp);
        int k = 0;
        do begin @(negedge clk); #1; k++; end while (!id_valid && k < 60);
        chk(tag, 64'({id_valid, id_instr, id_pc}), 64'({1'b1, instr_of(exp), exp}));
    endtask

    task automatic wait_two_inflight(input string tag);
        int k = 0;
        while (mq.size() != 2 && k < 40) begin @(posedge clk); #1; k++; end
        chk(tag, 64'(mq.size()), 64'(2));
    endtask

    // Memory model plus scoreboard: observe the cycle about to close, then drive its response.
    initial begin : mon
        logic [63:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                mq.delete();
                sb.delete();
                exp_pc = RST_PC;
                imem_resp_valid = 1'b0;
            end else begin
                if (redirect_valid) begin
                    chk("req_valid_on_redirect", 64'(imem_req_valid), 64'(0));
                    chk("id_valid_on_redirect", 64'(id_valid), 64'(0));
                    sb.delete();
                    exp_pc = {redirect_pc[31:2], 2'b00};
                end else begin
                    if (id_valid && id_ready) begin
                        chk("id_expected", 64'(sb.size() != 0), 64'(1));
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            chk("id_instr", 64'(id_instr), 64'(e[63:32]));
                            chk("id_pc", 64'(id_pc), 64'(e[31:0]));
                            n_id++;
                        end
                    end
                    if (imem_req_valid && imem_req_ready) begin
                        chk("req_addr", 64'(imem_req_addr), 64'(exp_pc));
                        sb.push_back({instr_of(exp_pc), exp_pc});
                        exp_pc += 32'd4;
                    end
                end
                if (mq.size() != 0 && mq[0].due <= cyc) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data = instr_of(mq[0].a);
                    void'(mq.pop_front());
                end else begin
                    imem_resp_valid = 1'b0;
                end
                if (imem_req_valid && imem_req_ready)
                    mq.push_back('{imem_req_addr, cyc + lat});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        bit hit;
        #2 rst_n = 1'b0;
        @(negedge clk); #1;
        chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
        chk("rst_id_valid", 64'(id_valid), 64'(0));
        chk("rst_id_instr", 64'(id_instr), 64'(0));
        chk("rst_id_pc", 64'(id_pc), 64'(0));
`ifdef FETCH_MISALIGN_CHK_EN
        chk("rst_misalign", 64'(misalign_err), 64'(0));
`endif
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk); #1;
        chk("boot_no_req", 64'(imem_req_valid), 64'(0));
        @(negedge clk); #1;
        chk("run_first_req", 64'({imem_req_valid, imem_req_addr}), 64'({1'b1, RST_PC}));
        // 1: streaming with a 1-cycle memory
        n0 = n_id;
        repeat (30) @(negedge clk);
        #1 chk("t1_throughput", 64'((n_id - n0) >= 15), 64'(1));
        // 2: decode stall fills the buffer and holds the head
        @(posedge clk); #1; id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (id_valid && sb.size() != 0) chk("t2_hold", {id_instr, id_pc}, sb[0]);
        end
        chk("t2_full_no_req", 64'({imem_req_valid, id_valid}), 64'(2'b01));
        chk("t2_fifo_level", 64'(sb.size()), 64'(FIFO_DEPTH));
        @(posedge clk); #1; id_ready = 1'b1;
        n0 = n_id;
        repeat (10) @(negedge clk);
        #1 chk("t2_resume", 64'((n_id - n0) >= 5), 64'(1));
        // 3: redirect with two requests outstanding
        @(posedge clk); #1; lat = 6;
        wait_two_inflight("t3_two_inflight");
        pulse(32'h100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk("t3_drain_no_req", 64'(imem_req_valid), 64'(0));
        end
        lat = 1;
        wait_id("t3_first_id", 32'h100);
        // 4: redirect coinciding with a response and a ready decode
        @(posedge clk); #1;
        hit = 1'b0;
        for (int k = 0; k < 40 && !hit; k++) begin
            hit = id_valid && mq.size() != 0 && mq[0].due <= cyc + 1;
            if (!hit) begin @(posedge clk); #1; end
        end
        chk("t4_setup", 64'(hit), 64'(1));
        pulse(32'h200);
        @(negedge clk); #1;
        chk("t4_fifo_empty", 64'(id_valid), 64'(0));
        wait_id("t4_first_id", 32'h200);
        // 5: PC wraps past the top of the address space
        @(posedge clk); #1;
        pulse(32'hFFFF_FFFC);
        wait_acc("t5_addr_top", 32'hFFFF_FFFC);
        wait_acc("t5_addr_wrap", 32'h0);
        // 6: misaligned redirect target
        @(posedge clk); #1; imem_req_ready = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("t6_mis_idle", 64'(misalign_err), 64'(0));
`endif
        pulse(32'h102);
        @(negedge clk); #1;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("t6_mis_pulse", 64'(misalign_err), 64'(1));
`endif
        @(negedge clk); #1;
`ifdef FETCH_MISALIGN_CHK_EN
        chk("t6_mis_clear", 64'(misalign_err), 64'(0));
`endif
        @(posedge clk); #1; imem_req_ready = 1'b1;
        wait_acc("t6_aligned_addr", 32'h100);
        // 7: asynchronous reset in the middle of a drain
        @(posedge clk); #1; lat = 6;
        wait_two_inflight("t7_two_inflight");
        pulse(32'h300);
        @(posedge clk); #3; rst_n = 1'b0;
        #1;
        chk("t7_req_valid", 64'(imem_req_valid), 64'(0));
        chk("t7_id_valid", 64'(id_valid), 64'(0));
        chk("t7_id_instr", 64'(id_instr), 64'(0));
        chk("t7_id_pc", 64'(id_pc), 64'(0));
        repeat (2) @(posedge clk);
        #1 lat = 1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("t7_boot_no_req", 64'(imem_req_valid), 64'(0));
        wait_acc("t7_restart_addr", RST_PC);
        wait_id("t7_restart_id", RST_PC);
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
